// File: rtl/idle_gate_controller_if.sv
// ----------------------------------------------------------------------------
// idle_gate_controller_if
//
// Purpose:
//   Groups the producer-facing handshake of the idle gate controller.
//   The upstream producer raises activity_i when it has work. It may raise
//   force_on_i to hold the downstream stage enabled. It feeds data only while
//   ready_o is high. gate_en_o drives the downstream register enable or ICG.
//
// Signals:
//   activity_i  producer -> controller  upstream has valid work this cycle
//   force_on_i  producer -> controller  block gating, keep/restore the enable
//   gate_en_o   controller -> producer  registered downstream enable
//   ready_o     controller -> producer  downstream may accept data
//   state_o     controller -> producer  0 RUN, 1 GATED, 2 WAKE
//
// Modports:
//   master  the upstream producer / test driver
//   slave   the controller
// ----------------------------------------------------------------------------
interface idle_gate_controller_if;
    logic       activity_i;
    logic       force_on_i;
    logic       gate_en_o;
    logic       ready_o;
    logic [1:0] state_o;

    modport master (
        output activity_i,
        output force_on_i,
        input  gate_en_o,
        input  ready_o,
        input  state_o
    );

    modport slave (
        input  activity_i,
        input  force_on_i,
        output gate_en_o,
        output ready_o,
        output state_o
    );
endinterface

// File: rtl/idle_gate_controller.sv
// ----------------------------------------------------------------------------
// idle_gate_controller
//
// Purpose:
//   Produces the register/ICG enable for a conditionally gated datapath stage.
//   After IDLE_CYCLES consecutive inactive cycles, the enable drops (GATED).
//   Renewed activity or force_on restores the enable (WAKE). ready_o then
//   rises WAKE_CYCLES edges later, and the block returns to RUN.
//   Every output is taken straight from a flop.
//
// Ports:
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   bus (slave)     activity_i, force_on_i in; gate_en_o, ready_o, state_o out
//   stat_clr_i      synchronous clear of the statistics counters
//   gated_cycles_o  saturating count of cycles spent in GATED
//   wake_events_o   saturating count of GATED->WAKE transitions
//
// Build option:
//   IDLE_GATE_STATS_EN  when defined, the statistics counters are built.
//                       When undefined, both statistics outputs read 0 and
//                       stat_clr_i has no effect.
// ----------------------------------------------------------------------------
module idle_gate_controller #(
    parameter int IDLE_CYCLES = 8,   // 1..255
    parameter int WAKE_CYCLES = 2,   // 1..255
    parameter int STAT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    idle_gate_controller_if.slave     bus,
    input  logic                      stat_clr_i,
    output logic [STAT_W-1:0]         gated_cycles_o,
    output logic [STAT_W-1:0]         wake_events_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_t;

    // idle_cnt compares against the last idle cycle, not the threshold.
    // The gating decision is made on the edge that ends cycle IDLE_CYCLES.
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES);

    state_t     state, state_next;
    logic       gate_en, gate_en_next;
    logic       ready, ready_next;
    logic [7:0] idle_cnt, idle_cnt_next;
    logic [7:0] wake_cnt, wake_cnt_next;
    logic       count_gated;    // this cycle is spent in GATED
    logic       count_wake;     // GATED->WAKE transition at this edge
    logic       wake_req;

    assign wake_req = bus.activity_i | bus.force_on_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            gate_en  <= 1'b1;
            ready    <= 1'b1;
            idle_cnt <= 8'd0;
            wake_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            gate_en  <= gate_en_next;
            ready    <= ready_next;
            idle_cnt <= idle_cnt_next;
            wake_cnt <= wake_cnt_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next    = state;
        gate_en_next  = gate_en;
        ready_next    = ready;
        idle_cnt_next = idle_cnt;
        wake_cnt_next = wake_cnt;
        count_gated   = 1'b0;
        count_wake    = 1'b0;

        case (state)
            RUN: begin
                gate_en_next = 1'b1;
                ready_next   = 1'b1;
                if (wake_req) begin
                    // Activity on the threshold cycle also lands here, so it
                    // prevents gating.
                    idle_cnt_next = 8'd0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next    = GATED;
                    gate_en_next  = 1'b0;
                    ready_next    = 1'b0;
                    idle_cnt_next = 8'd0;
                end else begin
                    idle_cnt_next = idle_cnt + 8'd1;
                end
            end

            GATED: begin
                count_gated  = 1'b1;
                gate_en_next = 1'b0;
                ready_next   = 1'b0;
                if (wake_req) begin
                    state_next    = WAKE;
                    gate_en_next  = 1'b1;
                    wake_cnt_next = WAKE_LOAD;
                    count_wake    = 1'b1;
                end
            end

            WAKE: begin
                // Requests are ignored here. The producer holds its work
                // until ready rises.
                gate_en_next = 1'b1;
                ready_next   = 1'b0;
                if (wake_cnt == 8'd1) begin
                    state_next    = RUN;
                    ready_next    = 1'b1;
                    idle_cnt_next = 8'd0;
                    wake_cnt_next = 8'd0;
                end else begin
                    wake_cnt_next = wake_cnt - 8'd1;
                end
            end

            default: begin
                state_next    = RUN;
                gate_en_next  = 1'b1;
                ready_next    = 1'b1;
                idle_cnt_next = 8'd0;
                wake_cnt_next = 8'd0;
            end
        endcase
    end

    assign bus.gate_en_o = gate_en;
    assign bus.ready_o   = ready;
    assign bus.state_o   = state;

`ifdef IDLE_GATE_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    logic [STAT_W-1:0] gated_cycles;
    logic [STAT_W-1:0] wake_events;

    // ---------------- statistics ----------------
    // A clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cycles <= '0;
            wake_events  <= '0;
        end else if (stat_clr_i) begin
            gated_cycles <= '0;
            wake_events  <= '0;
        end else begin
            if (count_gated) gated_cycles <= sat_inc(gated_cycles);
            if (count_wake)  wake_events  <= sat_inc(wake_events);
        end
    end

    assign gated_cycles_o = gated_cycles;
    assign wake_events_o  = wake_events;
`else
    // Statistics are not built. These signals are gathered only so that they
    // are visibly consumed.
    logic unused_stats;
    assign unused_stats   = ^{stat_clr_i, count_gated, count_wake};
    assign gated_cycles_o = '0;
    assign wake_events_o  = '0;
`endif

endmodule
